fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V core. It owns the program counter, runs a single-outstanding req/ack handshake with instruction memory, and buffers one fetched instruction with its PC. It sits directly upstream of the IF/ID pipeline register and drives that register's data and enable. Stall and redirect (branch/jump/flush) inputs come from the hazard and execute logic.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and keeps one request in flight to
// instruction memory. Holds one fetched instruction that feeds IF/ID.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_pc4,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic                  ifid_en
);

    localparam logic [DATA_WIDTH-1:0] NOP   = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] FOUR  = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN = ~DATA_WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_WAIT,
        S_DROP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] req_addr;
    logic                  buf_free;
    logic                  go;
    logic                  cap;
    logic [DATA_WIDTH-1:0] addr;
    logic                  redir_act;

    // Handshake toward IF/ID; quiet while reset is held.
    always_comb begin
        ifid_en   = rst & if_valid & ~stall & ~redirect;
        buf_free  = ~if_valid | ifid_en;
        if_pc4    = if_pc + FOUR;
        redir_act = redirect & (state != S_IDLE);
    end

    // Next state, request and capture decisions.
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        cap       = 1'b0;
        addr      = req_addr;
        unique case (state)
            S_IDLE: begin
                state_nxt = S_READY;
            end
            S_READY: begin
                addr = pc;
                go   = buf_free & ~redirect;
                cap  = go & imem_ack;
                if (go && !imem_ack) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                go  = 1'b1;
                cap = imem_ack & ~redirect;
                if (imem_ack) begin
                    state_nxt = S_READY;
                end else if (redirect) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                go = 1'b1;
                if (imem_ack) begin
                    state_nxt = S_READY;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        imem_req  = go & rst;
        imem_addr = addr;
    end

    // State register plus PC, outstanding address and output buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_addr <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP;
        end else begin
            state <= state_nxt;
            if (state == S_READY && go && !imem_ack) begin
                req_addr <= pc;
            end
            if (redir_act) begin
                pc       <= redirect_pc & ALIGN;
                if_valid <= 1'b0;
            end else if (cap) begin
                pc       <= addr + FOUR;
                if_valid <= 1'b1;
                if_pc    <= addr;
                if_instr <= imem_rdata;
            end else if (ifid_en) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small wait-state memory responder.
// Instruction data is the bitwise inverse of the fetch address.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        ifid_en;

    int n_chk;
    int n_err;
    int mem_wait;
    int wcnt;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_instr    (if_instr),
        .ifid_en     (ifid_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after mem_wait cycles of a held request.
    always_comb begin
        imem_ack   = imem_req && (wcnt >= mem_wait);
        imem_rdata = ~imem_addr;
    end

    // Count cycles the current request has waited.
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        mem_wait    = 0;
        wcnt        = 0;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        cyc();
        cyc();
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_en", {31'b0, ifid_en}, 32'd0);

        rst = 1'b1;
        #1;
        chk("idle_req", {31'b0, imem_req}, 32'd0);

        cyc();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0040_0000);

        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("seq_valid", {31'b0, if_valid}, 32'd1);
            chk("seq_pc", if_pc, 32'h0040_0000 + 32'(4 * i));
            chk("seq_instr", if_instr, ~(32'h0040_0000 + 32'(4 * i)));
            chk("seq_en", {31'b0, ifid_en}, 32'd1);
            chk("seq_addr", imem_addr, 32'h0040_0004 + 32'(4 * i));
        end

        cyc();
        stall = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) cyc();
            chk("stl_pc", if_pc, 32'h0040_0010);
            chk("stl_instr", if_instr, ~32'h0040_0010);
            chk("stl_req", {31'b0, imem_req}, 32'd0);
            chk("stl_en", {31'b0, ifid_en}, 32'd0);
        end

        cyc();
        stall = 1'b0;
        #1;
        chk("rel_pc", if_pc, 32'h0040_0010);
        chk("rel_en", {31'b0, ifid_en}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0040_0014);
        cyc();
        chk("rel_next", if_pc, 32'h0040_0014);

        mem_wait = 2;
        #1;
        chk("w2_req0", {31'b0, imem_req}, 32'd1);
        chk("w2_ack0", {31'b0, imem_ack}, 32'd0);
        chk("w2_addr0", imem_addr, 32'h0040_0018);
        cyc();
        chk("w2_req1", {31'b0, imem_req}, 32'd1);
        chk("w2_addr1", imem_addr, 32'h0040_0018);
        chk("w2_val1", {31'b0, if_valid}, 32'd0);
        cyc();
        chk("w2_req2", {31'b0, imem_req}, 32'd1);
        chk("w2_addr2", imem_addr, 32'h0040_0018);
        chk("w2_ack2", {31'b0, imem_ack}, 32'd1);
        cyc();
        chk("w2_val", {31'b0, if_valid}, 32'd1);
        chk("w2_pc", if_pc, 32'h0040_0018);
        chk("w2_instr", if_instr, ~32'h0040_0018);
        chk("w2_nxt", imem_addr, 32'h0040_001C);

        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0102;
        #1;
        chk("rw_req", {31'b0, imem_req}, 32'd1);
        chk("rw_addr", imem_addr, 32'h0040_001C);
        cyc();
        redirect = 1'b0;
        #1;
        chk("drop_req", {31'b0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr, 32'h0040_001C);
        chk("drop_val", {31'b0, if_valid}, 32'd0);
        cyc();
        mem_wait = 1;
        #1;
        chk("rd_val", {31'b0, if_valid}, 32'd0);
        chk("rd_req", {31'b0, imem_req}, 32'd1);
        chk("rd_addr", imem_addr, 32'h0040_0100);

        cyc();
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("ra_ack", {31'b0, imem_ack}, 32'd1);
        chk("ra_en", {31'b0, ifid_en}, 32'd0);
        cyc();
        redirect = 1'b0;
        stall    = 1'b0;
        mem_wait = 0;
        #1;
        chk("ra_val", {31'b0, if_valid}, 32'd0);
        chk("ra_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wr_pc", if_pc, 32'hFFFF_FFFC);
        chk("wr_pc4", if_pc4, 32'h0);
        chk("wr_instr", if_instr, 32'h0000_0003);
        chk("wr_addr", imem_addr, 32'h0);
        cyc();
        chk("wr_zero", if_pc, 32'h0);

        redirect    = 1'b1;
        redirect_pc = 32'h0040_0203;
        #1;
        chk("ri_req", {31'b0, imem_req}, 32'd0);
        chk("ri_en", {31'b0, ifid_en}, 32'd0);
        cyc();
        redirect = 1'b0;
        #1;
        chk("ri_val", {31'b0, if_valid}, 32'd0);
        chk("ri_addr", imem_addr, 32'h0040_0200);
        chk("ri_req2", {31'b0, imem_req}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
